// File: rtl/car_controller.sv
// Four-lane car mover for a frogger-style game: one step per frame on VSync
// falling edge, wrap-around horizontal motion, frog/car bounding-box collision pulse.
module car_controller #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int TILE_SIZE      = 32,
  parameter int LANE_Y_1       = 64,
  parameter int LANE_Y_2       = 160,
  parameter int LANE_Y_3       = 256,
  parameter int LANE_Y_4       = 352,
  parameter int CAR_START_X_1  = 0,
  parameter int CAR_START_X_2  = 160,
  parameter int CAR_START_X_3  = 320,
  parameter int CAR_START_X_4  = 480,
  parameter int BASE_STEP_1    = 1,
  parameter int BASE_STEP_2    = 2,
  parameter int BASE_STEP_3    = 3,
  parameter int BASE_STEP_4    = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_VGA_VSync,
  input  logic [9:0] i_Frog_X,
  input  logic [8:0] i_Frog_Y,
  input  logic       i_Level_Up,
  input  logic       i_Pause,
  output logic [9:0] o_Car_1X,
  output logic [9:0] o_Car_2X,
  output logic [9:0] o_Car_3X,
  output logic [9:0] o_Car_4X,
  output logic [8:0] o_Car_1Y,
  output logic [8:0] o_Car_2Y,
  output logic [8:0] o_Car_3Y,
  output logic [8:0] o_Car_4Y,
  output logic       o_Collision,
  output logic [2:0] o_Level
);

  localparam logic [10:0] L_H    = 11'(H_VISIBLE_AREA);
  localparam logic [10:0] L_TILE = 11'(TILE_SIZE);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_CHECK = 2'd1,
    S_MOVE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_vsync_prev;
  logic       w_tick;
  logic       w_eval;
  logic       w_any_hit;
  logic [4:0] w_step_1;
  logic [4:0] w_step_2;
  logic [4:0] w_step_3;
  logic [4:0] w_step_4;

  // Straight bounding-box overlap; a car straddling the wrap seam is not split.
  function automatic logic f_overlap(input logic [9:0] car_x, input logic [8:0] car_y,
                                     input logic [9:0] frog_x, input logic [8:0] frog_y);
    logic x_hit;
    logic y_hit;
    x_hit = ({1'b0, frog_x} < ({1'b0, car_x} + L_TILE)) &&
            ({1'b0, car_x} < ({1'b0, frog_x} + L_TILE));
    y_hit = ({2'b00, frog_y} < ({2'b00, car_y} + L_TILE)) &&
            ({2'b00, car_y} < ({2'b00, frog_y} + L_TILE));
    return x_hit && y_hit;
  endfunction

  function automatic logic [9:0] f_move_right(input logic [9:0] x, input logic [4:0] step);
    logic [10:0] sum;
    sum = {1'b0, x} + {6'b000000, step};
    if (sum >= L_H) begin
      return 10'(sum - L_H);
    end else begin
      return 10'(sum);
    end
  endfunction

  function automatic logic [9:0] f_move_left(input logic [9:0] x, input logic [4:0] step);
    if ({1'b0, x} < {6'b000000, step}) begin
      return 10'({1'b0, x} + L_H - {6'b000000, step});
    end else begin
      return 10'({1'b0, x} - {6'b000000, step});
    end
  endfunction

  assign w_tick   = r_vsync_prev & ~i_VGA_VSync;
  assign w_step_1 = 5'(BASE_STEP_1) + {2'b00, o_Level};
  assign w_step_2 = 5'(BASE_STEP_2) + {2'b00, o_Level};
  assign w_step_3 = 5'(BASE_STEP_3) + {2'b00, o_Level};
  assign w_step_4 = 5'(BASE_STEP_4) + {2'b00, o_Level};

  assign o_Car_1Y = 9'(LANE_Y_1);
  assign o_Car_2Y = 9'(LANE_Y_2);
  assign o_Car_3Y = 9'(LANE_Y_3);
  assign o_Car_4Y = 9'(LANE_Y_4);

  // FSM state register and VSync edge history
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= S_WAIT;
      r_vsync_prev <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_vsync_prev <= i_VGA_VSync;
    end
  end

  // Next-state logic; edges outside S_WAIT are dropped, pause skips the frame
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT: begin
        if (w_tick && !i_Pause) begin
          w_next_state = S_CHECK;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_CHECK: w_next_state = S_MOVE;
      S_MOVE:  w_next_state = S_WAIT;
      default: w_next_state = S_WAIT;
    endcase
  end

  // FSM outputs: collision evaluation and position update both fire leaving S_CHECK
  always_comb begin
    w_eval    = 1'b0;
    w_any_hit = 1'b0;
    case (r_state)
      S_CHECK: begin
        w_eval    = 1'b1;
        w_any_hit = f_overlap(o_Car_1X, o_Car_1Y, i_Frog_X, i_Frog_Y) ||
                    f_overlap(o_Car_2X, o_Car_2Y, i_Frog_X, i_Frog_Y) ||
                    f_overlap(o_Car_3X, o_Car_3Y, i_Frog_X, i_Frog_Y) ||
                    f_overlap(o_Car_4X, o_Car_4Y, i_Frog_X, i_Frog_Y);
      end
      default: begin
        w_eval    = 1'b0;
        w_any_hit = 1'b0;
      end
    endcase
  end

  // Car positions and the collision pulse, updated together from pre-move state
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Car_1X    <= 10'(CAR_START_X_1);
      o_Car_2X    <= 10'(CAR_START_X_2);
      o_Car_3X    <= 10'(CAR_START_X_3);
      o_Car_4X    <= 10'(CAR_START_X_4);
      o_Collision <= 1'b0;
    end else begin
      o_Collision <= w_eval & w_any_hit;
      if (w_eval) begin
        o_Car_1X <= f_move_right(o_Car_1X, w_step_1);
        o_Car_2X <= f_move_left(o_Car_2X, w_step_2);
        o_Car_3X <= f_move_right(o_Car_3X, w_step_3);
        o_Car_4X <= f_move_left(o_Car_4X, w_step_4);
      end
    end
  end

  // Difficulty level, saturating at 7
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Level <= 3'd0;
    end else if (i_Level_Up && (o_Level != 3'd7)) begin
      o_Level <= o_Level + 3'd1;
    end
  end

endmodule

// File: tb/tb_car_controller.sv
// Directed bench for car_controller: per-frame vector table plus hand-built
// sequences for ignored VSync edges, reset mid-frame and reset release.
module tb_car_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic [9:0] frog_x;
  logic [8:0] frog_y;
  logic       lvl_up;
  logic       pause;

  logic [9:0] c1x, c2x, c3x, c4x, d1x, d2x, d3x, d4x;
  logic [8:0] c1y, c2y, c3y, c4y, d1y, d2y, d3y, d4y;
  logic       coll, coll2;
  logic [2:0] lvl, lvl2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  car_controller dut (
    .i_Clk(clk), .i_Reset(rst), .i_VGA_VSync(vsync), .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
    .i_Level_Up(lvl_up), .i_Pause(pause),
    .o_Car_1X(c1x), .o_Car_2X(c2x), .o_Car_3X(c3x), .o_Car_4X(c4x),
    .o_Car_1Y(c1y), .o_Car_2Y(c2y), .o_Car_3Y(c3y), .o_Car_4Y(c4y),
    .o_Collision(coll), .o_Level(lvl)
  );

  car_controller #(.CAR_START_X_1(639), .CAR_START_X_2(1)) dut_wrap (
    .i_Clk(clk), .i_Reset(rst), .i_VGA_VSync(vsync), .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
    .i_Level_Up(lvl_up), .i_Pause(pause),
    .o_Car_1X(d1x), .o_Car_2X(d2x), .o_Car_3X(d3x), .o_Car_4X(d4x),
    .o_Car_1Y(d1y), .o_Car_2Y(d2y), .o_Car_3Y(d3y), .o_Car_4Y(d4y),
    .o_Collision(coll2), .o_Level(lvl2)
  );

  typedef struct {
    int ups;
    bit pause;
    int fx;
    int fy;
    int x1, x2, x3, x4;
    bit coll;
    int lvl;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_x(input string tag, input int x1, input int x2, input int x3, input int x4);
    chk({tag, " car1X"}, int'(c1x), x1);
    chk({tag, " car2X"}, int'(c2x), x2);
    chk({tag, " car3X"}, int'(c3x), x3);
    chk({tag, " car4X"}, int'(c4x), x4);
  endtask

  task automatic pulse_level(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); lvl_up = 1'b1;
      @(negedge clk); lvl_up = 1'b0;
    end
  endtask

  // One frame: VSync falls, check D+1 (unchanged), D+2 (result), D+3 (pulse gone)
  task automatic run_frame(input int idx, input int px1, input int px2, input int px3, input int px4);
    string tag;
    tag = $sformatf("vec%0d", idx);
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(posedge clk); #1;
    chk_x({tag, " D+1"}, px1, px2, px3, px4);
    chk({tag, " D+1 coll"}, int'(coll), 0);
    @(posedge clk); #1;
    chk_x({tag, " D+2"}, tbl[idx].x1, tbl[idx].x2, tbl[idx].x3, tbl[idx].x4);
    chk({tag, " D+2 coll"}, int'(coll), int'(tbl[idx].coll));
    chk({tag, " level"}, int'(lvl), tbl[idx].lvl);
    @(posedge clk); #1;
    chk({tag, " D+3 coll"}, int'(coll), 0);
    chk_x({tag, " D+3"}, tbl[idx].x1, tbl[idx].x2, tbl[idx].x3, tbl[idx].x4);
    @(negedge clk); vsync = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p1, p2, p3, p4;

    tbl[0] = '{0, 1'b0,   0, 480,  1, 158, 323, 476, 1'b0, 0};
    tbl[1] = '{0, 1'b0, 354, 256,  2, 156, 326, 472, 1'b1, 0};
    tbl[2] = '{0, 1'b0, 358, 256,  3, 154, 329, 468, 1'b0, 0};
    tbl[3] = '{0, 1'b1, 329, 256,  3, 154, 329, 468, 1'b0, 0};
    tbl[4] = '{0, 1'b1, 329, 256,  3, 154, 329, 468, 1'b0, 0};
    tbl[5] = '{0, 1'b1, 329, 256,  3, 154, 329, 468, 1'b0, 0};
    tbl[6] = '{3, 1'b0,   0, 480,  7, 149, 335, 461, 1'b0, 3};
    tbl[7] = '{10, 1'b0,  0, 480, 15, 140, 345, 450, 1'b0, 7};

    rst = 1'b1; vsync = 1'b0; frog_x = 10'd0; frog_y = 9'd480; lvl_up = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    // VSync already low at release must not produce a tick
    repeat (4) @(posedge clk); #1;
    chk_x("reset", 0, 160, 320, 480);
    chk("reset car1Y", int'(c1y), 64);
    chk("reset car2Y", int'(c2y), 160);
    chk("reset car3Y", int'(c3y), 256);
    chk("reset car4Y", int'(c4y), 352);
    chk("reset level", int'(lvl), 0);
    chk("reset coll", int'(coll), 0);
    chk("reset wrap car1X", int'(d1x), 639);
    chk("reset wrap car2X", int'(d2x), 1);
    @(negedge clk); vsync = 1'b1;

    p1 = 0; p2 = 160; p3 = 320; p4 = 480;
    for (int i = 0; i < 8; i++) begin
      pulse_level(tbl[i].ups);
      @(negedge clk);
      pause  = tbl[i].pause;
      frog_x = 10'(tbl[i].fx);
      frog_y = 9'(tbl[i].fy);
      run_frame(i, p1, p2, p3, p4);
      if (i == 0) begin
        chk("wrap car1X", int'(d1x), 0);
        chk("wrap car2X", int'(d2x), 639);
      end
      p1 = tbl[i].x1; p2 = tbl[i].x2; p3 = tbl[i].x3; p4 = tbl[i].x4;
    end
    pause = 1'b0;

    // Falling edge arriving while in S_MOVE is dropped
    frog_x = 10'd0; frog_y = 9'd480;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk_x("ignored edge", 23, 131, 355, 439);
    chk("ignored edge coll", int'(coll), 0);
    @(negedge clk); vsync = 1'b1;

    // Reset in D+1 aborts the frame, even with the frog on car 3
    frog_x = 10'd355; frog_y = 9'd256;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_x("mid reset", 0, 160, 320, 480);
    chk("mid reset level", int'(lvl), 0);
    @(posedge clk); #1;
    chk("mid reset coll", int'(coll), 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_x("post reset", 0, 160, 320, 480);
    chk("post reset coll", int'(coll), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
